// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch stage sitting directly behind the PC register. It issues
// one handshaked read per instruction to instruction memory, captures the
// returned word into an output register for decode, and pulses pc_en for one
// cycle on the edge that loads that word so the PC register advances.
// A redirect flush discards the held or in-flight instruction, and a watchdog
// raises a sticky fetch_err if memory never answers.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   run          fetch enable; 0 parks the FSM in IDLE after the current fetch
//   pc           current PC from the PC register
//   pc_en        one-cycle pulse, PC register loads next PC
//   imem_req     memory request valid
//   imem_addr    request address (follows pc while requesting)
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   flush        discard held/in-flight instruction (pc already redirected)
//   id_ready     decode accepts the held instruction this cycle
//   inst_valid   instruction register holds a valid word
//   inst         fetched instruction
//   inst_pc      address the instruction was fetched from
//   fetch_err    sticky watchdog error
//
// Handshakes: a memory request transfers on a cycle where imem_req and
// imem_gnt are both high; until then imem_req stays high and imem_addr may
// change with pc. An instruction transfers to decode on a cycle where
// inst_valid and id_ready are both high; inst/inst_pc are stable until then.
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              flush,
    input  logic              id_ready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Watchdog value seen in the last WAIT cycle allowed without a response.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        wdog;
    logic              drop;
    logic [ADDR_W-1:0] req_pc;

    logic rsp_take;     // response accepted into the instruction register
    logic rsp_drop;     // response discarded because of a flush
    logic wdog_expire;  // last permitted WAIT cycle passed with no response
    logic hold_leave;   // held instruction consumed or flushed

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        // A flush in the same cycle as rvalid counts as a drop.
        rsp_take    = (state == S_WAIT) && imem_rvalid && !drop && !flush;
        rsp_drop    = (state == S_WAIT) && imem_rvalid && (drop || flush);
        wdog_expire = (state == S_WAIT) && !imem_rvalid && (wdog == WDOG_LAST);
        // Flush wins over id_ready; both free the instruction register.
        hold_leave  = (state == S_HOLD) && (flush || id_ready);
        imem_req    = (state == S_REQ);
        imem_addr   = (state == S_REQ) ? pc : '0;

        case (state)
            S_IDLE: if (run) state_nx = S_REQ;
            S_REQ:  if (imem_gnt) state_nx = S_WAIT;
            S_WAIT: begin
                if (rsp_take) begin
                    state_nx = S_HOLD;
                end else if (rsp_drop) begin
                    state_nx = run ? S_REQ : S_IDLE;
                end else if (wdog_expire) begin
                    state_nx = S_ERR;
                end
            end
            S_HOLD: if (hold_leave) state_nx = run ? S_REQ : S_IDLE;
            S_ERR:  state_nx = S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_en      <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
            wdog       <= '0;
            drop       <= 1'b0;
            req_pc     <= '0;
        end else begin
            // Only the edge that loads inst advances the PC; since every load
            // is followed by at least HOLD and REQ, pulses are never adjacent.
            pc_en <= rsp_take;

            if ((state == S_REQ) && imem_gnt) begin
                req_pc <= pc;
                wdog   <= '0;
            end else if ((state == S_WAIT) && !imem_rvalid) begin
                wdog <= wdog + 8'd1;
            end

            // The drop flag lives for one transaction: set by a flush while
            // waiting, cleared by the response it discards.
            if (state == S_WAIT) begin
                if (imem_rvalid) begin
                    drop <= 1'b0;
                end else if (flush) begin
                    drop <= 1'b1;
                end
            end

            if (rsp_take) begin
                inst       <= imem_rdata;
                inst_pc    <= req_pc;
                inst_valid <= 1'b1;
            end else if (hold_leave) begin
                inst_valid <= 1'b0;
            end

            if (wdog_expire) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed walk through reset, latency, decode backpressure, grant delay,
// flush and watchdog behaviour, then a randomized phase where the bench plays
// instruction memory and the PC register. The random phase checks that decode
// sees the instruction stream a program counter would produce: consecutive
// word addresses restarting at each redirect target, each word matching the
// memory image.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              pc_en;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              flush;
    logic              id_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_err;

    ifetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .pc         (pc),
        .pc_en      (pc_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_ready   (id_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err)
    );

    int   total = 0;
    int   bad   = 0;
    logic pc_en_q = 1'b0;

    // ---------------- scoreboard ----------------
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Memory image: every word address holds a distinct scrambled value.
    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // PC register model: loads pc+4 on the edge that ends a pc_en cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        if (pc_en_q) pc = pc + 32'd4;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    // pc_en must never be high in two consecutive cycles.
    always @(negedge clock) begin
        if (reset) check("pc_en_gap", 64'(pc_en & pc_en_q), 64'd0);
        pc_en_q <= pc_en;
    end

    // ---------------- random-phase state ----------------
    logic              fl;
    logic              rv;
    logic              outstanding;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] exp_pc;
    int                delay;
    int                accepted;

    initial begin
        run = 0; pc = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        flush = 0; id_ready = 0;
        outstanding = 0; out_addr = '0; delay = 0; accepted = 0;
        fl = 0; rv = 0; target = '0; exp_pc = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        at_neg();
        check("rst_pc_en", 64'(pc_en), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);

        // ---------------- minimum latency ----------------
        tick(); reset = 1; run = 1;
        at_neg();
        check("idle_no_req", 64'(imem_req), 64'd0);
        tick(); imem_gnt = 1;                                   // REQ, cycle 0
        at_neg();
        check("c0_req", 64'(imem_req), 64'd1);
        check("c0_addr", 64'(imem_addr), 64'h0);
        tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093; // cycle 1
        at_neg();
        check("c1_req_low", 64'(imem_req), 64'd0);
        check("c1_inst_valid", 64'(inst_valid), 64'd0);
        check("c1_pc_en", 64'(pc_en), 64'd0);
        tick(); imem_rvalid = 0; imem_rdata = '0; id_ready = 0; // cycle 2
        at_neg();
        check("c2_inst_valid", 64'(inst_valid), 64'd1);
        check("c2_inst", 64'(inst), 64'h0050_0093);
        check("c2_inst_pc", 64'(inst_pc), 64'h0);
        check("c2_pc_en", 64'(pc_en), 64'd1);

        // ---------------- decode backpressure ----------------
        for (int i = 0; i < 5; i++) begin
            tick();
            at_neg();
            check("bp_pc_en", 64'(pc_en), 64'd0);
            check("bp_valid", 64'(inst_valid), 64'd1);
            check("bp_inst", 64'(inst), 64'h0050_0093);
            check("bp_inst_pc", 64'(inst_pc), 64'h0);
            check("bp_no_req", 64'(imem_req), 64'd0);
        end
        tick(); id_ready = 1;
        at_neg();
        check("bp_accept_valid", 64'(inst_valid), 64'd1);

        // ---------------- delayed grant, pc moving ----------------
        tick(); id_ready = 0;
        at_neg();
        check("next_valid_low", 64'(inst_valid), 64'd0);
        check("next_req", 64'(imem_req), 64'd1);
        check("next_addr", 64'(imem_addr), 64'h4);
        tick(); pc = 32'h10;
        at_neg();
        check("gd_addr_10", 64'(imem_addr), 64'h10);
        tick(); pc = 32'h18;
        at_neg();
        check("gd_addr_18", 64'(imem_addr), 64'h18);
        tick(); pc = 32'h20; imem_gnt = 1;
        at_neg();
        check("gd_req", 64'(imem_req), 64'd1);
        check("gd_addr_20", 64'(imem_addr), 64'h20);
        tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1122_3344;
        at_neg();
        check("gd_wait_req", 64'(imem_req), 64'd0);
        tick(); imem_rvalid = 0; id_ready = 1;
        at_neg();
        check("gd_valid", 64'(inst_valid), 64'd1);
        check("gd_inst_pc", 64'(inst_pc), 64'h20);
        check("gd_inst", 64'(inst), 64'h1122_3344);

        // ---------------- flush in WAIT ----------------
        tick(); id_ready = 0; imem_gnt = 1;
        at_neg();
        check("fw_addr", 64'(imem_addr), 64'h24);
        tick(); imem_gnt = 0; flush = 1; pc = 32'h100;
        at_neg();
        check("fw_wait", 64'(imem_req), 64'd0);
        tick(); flush = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        at_neg();
        check("fw_valid_a", 64'(inst_valid), 64'd0);
        tick(); imem_rvalid = 0; imem_gnt = 1;
        at_neg();
        check("fw_valid_b", 64'(inst_valid), 64'd0);
        check("fw_pc_en", 64'(pc_en), 64'd0);
        check("fw_req", 64'(imem_req), 64'd1);
        check("fw_addr_new", 64'(imem_addr), 64'h100);

        // ---------------- watchdog ----------------
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick(); imem_gnt = 0;
            at_neg();
            check("wd_not_yet", 64'(fetch_err), 64'd0);
        end
        tick();
        at_neg();
        check("wd_err", 64'(fetch_err), 64'd1);
        check("wd_no_req", 64'(imem_req), 64'd0);
        tick(); imem_rvalid = 1; imem_rdata = 32'hCAFE_F00D; flush = 1; imem_gnt = 1;
        at_neg();
        tick(); imem_rvalid = 0; flush = 0; imem_gnt = 0;
        at_neg();
        check("err_sticky", 64'(fetch_err), 64'd1);
        check("err_valid", 64'(inst_valid), 64'd0);
        check("err_pc_en", 64'(pc_en), 64'd0);
        check("err_req", 64'(imem_req), 64'd0);
        check("err_inst_kept", 64'(inst), 64'h1122_3344);
        #2; reset = 0; #1;
        check("async_clr_err", 64'(fetch_err), 64'd0);
        check("async_clr_inst", 64'(inst), 64'd0);

        // ---------------- flush with id_ready in HOLD ----------------
        tick();
        tick(); reset = 1; run = 1; pc = 32'h200;
        tick(); imem_gnt = 1;
        at_neg();
        check("fh_addr", 64'(imem_addr), 64'h200);
        tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA5A5_0001;
        tick(); imem_rvalid = 0; id_ready = 0;
        at_neg();
        check("fh_valid", 64'(inst_valid), 64'd1);
        tick(); flush = 1; id_ready = 1; pc = 32'h300;
        at_neg();
        check("fh_valid_pre", 64'(inst_valid), 64'd1);
        tick(); flush = 0; id_ready = 0; imem_gnt = 1;
        at_neg();
        check("fh_valid_low", 64'(inst_valid), 64'd0);
        check("fh_pc_en", 64'(pc_en), 64'd0);
        check("fh_req", 64'(imem_req), 64'd1);
        check("fh_addr_new", 64'(imem_addr), 64'h300);

        // ---------------- reset mid-WAIT ----------------
        tick(); imem_gnt = 0;
        at_neg();
        check("rw_in_wait", 64'(imem_req), 64'd0);
        #2; reset = 0; #1;
        check("rw_pc_en", 64'(pc_en), 64'd0);
        check("rw_req", 64'(imem_req), 64'd0);
        check("rw_addr", 64'(imem_addr), 64'd0);
        check("rw_valid", 64'(inst_valid), 64'd0);
        check("rw_inst", 64'(inst), 64'd0);
        check("rw_inst_pc", 64'(inst_pc), 64'd0);
        check("rw_err", 64'(fetch_err), 64'd0);
        run = 0;
        tick(); reset = 1; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
        at_neg();
        tick(); imem_rvalid = 0;
        at_neg();
        check("late_rv_valid", 64'(inst_valid), 64'd0);
        check("late_rv_pc_en", 64'(pc_en), 64'd0);
        check("late_rv_inst", 64'(inst), 64'd0);

        // ---------------- randomized stream ----------------
        reset = 0;
        tick(); tick();
        reset = 1; pc = '0; run = 1;
        exp_q.delete();
        exp_q.push_back('0);
        outstanding = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            // Redirects avoid the pc_en cycle so the PC register never has
            // to choose between a redirect and an increment on one edge.
            fl = 1'b0;
            if (!pc_en && ($urandom_range(0, 24) == 0)) begin
                fl = 1'b1;
                target = 32'($urandom_range(0, 1023)) << 2;
                pc = target;
                exp_q.delete();
                exp_q.push_back(target);
            end
            flush    = fl;
            run      = ($urandom_range(0, 19) != 0);
            imem_gnt = ($urandom_range(0, 2) != 0);
            id_ready = 1'($urandom_range(0, 1));
            rv = 1'b0;
            if (outstanding) begin
                if (delay == 0) rv = 1'b1;
                else delay--;
            end
            imem_rvalid = rv;
            imem_rdata  = rv ? mem_fn(out_addr) : $urandom();
            at_neg();
            check("rnd_no_err", 64'(fetch_err), 64'd0);
            if (outstanding) check("rnd_no_req_in_flight", 64'(imem_req), 64'd0);
            if (imem_req) check("rnd_req_addr", 64'(imem_addr), 64'(pc));
            if (inst_valid && id_ready && !flush) begin
                exp_pc = exp_q.pop_front();
                check("rnd_inst_pc", 64'(inst_pc), 64'(exp_pc));
                check("rnd_inst", 64'(inst), 64'(mem_fn(exp_pc)));
                exp_q.push_back(exp_pc + 32'd4);
                accepted++;
            end
            if (rv) outstanding = 1'b0;
            if (imem_req && imem_gnt) begin
                outstanding = 1'b1;
                out_addr    = imem_addr;
                delay       = $urandom_range(0, 8);
            end
        end
        check("rnd_progress", 64'(accepted > 50), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
